tod_counter: RTL
================

# tod_counter

- Time-of-day source for the alarm clock.
- Keeps a 24-hour BCD time hh:mm:ss on a 24-bit bus, advanced by a 1 Hz tick derived from the board clock.
- Supports direct load and per-field manual setting.
- Its cnt output is the current-time bus that the alarm comparator reads.
- Also provides a seconds strobe and an optional top-of-hour chime.

## Interface
- CLK_HZ, 50_000_000: clk frequency; prescaler divides by exactly this value.
- CHIME_SECS, 5: number of 1 Hz ticks the chime stays high (1..15).
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- set_mode  in  1  1 = setting: time frozen, increments allowed; 0 = run.
- sel  in  2  field select in set mode: 00 seconds, 01 minutes, 10 hours, 11 none.
- inc  in  1  raw increment button level; synchronised internally.
- ld  in  1  synchronous load strobe; one cycle high loads ld_val.
- ld_val  in  24  BCD time to load, {h1,h0,m1,m0,s1,s0}, 4 bits each.
- cnt  out  24  current BCD time, same packing as ld_val.
- sec_tick  out  1  one-cycle pulse on each cycle where run mode advanced cnt.
- chime  out  1  top-of-hour chime level.

## Operation
- Digit limits:
  - s0, m0: 0..9.
  - s1, m1: 0..5.
  - Hours: 00..23 as a pair; h0 runs 0..9, or 0..3 when h1 = 2.
- Prescaler:
  - Counts 0..CLK_HZ-1.
  - The internal tick fires on the cycle it equals CLK_HZ-1, and the prescaler returns to 0 on that cycle.
  - In set mode the prescaler is held at 0, so the first run-mode tick comes CLK_HZ cycles after set_mode falls.
- Run mode, on each tick:
  - Increment s0 with a full ripple carry through s1, m0, m1, h0, h1.
  - 23:59:59 wraps to 00:00:00.
  - sec_tick pulses.
- Set mode:
  - inc passes through a two-flop synchroniser (inc_s1, inc_s2) plus a delay flop inc_s3.
  - A rising edge is inc_s2 & ~inc_s3.
  - Each edge increments the selected field modulo its range, with no carry into the next field: seconds 59→00, minutes 59→00, hours 23→00.
  - sel = 11 ignores edges.
  - sec_tick stays 0.
- Load:
  - ld = 1 replaces cnt with ld_val.
  - Each field that is not valid BCD in range is replaced by 00; the other fields load as given.
  - Range checks per field: seconds ≤ 59, minutes ≤ 59, hours ≤ 23, every digit ≤ 9.
- Priority within one cycle: ld > set-mode increment > run tick.
  - If ld and a tick coincide, the load wins.
  - That tick is lost, and sec_tick = 0 that cycle.
- Mode changes: switching set_mode mid-second discards the partial prescaler count. No carry is lost from cnt itself.

## Timing
- Reset values:
  - cnt = 24'h000000.
  - Prescaler = 0.
  - sec_tick = 0, chime = 0.
  - Synchroniser flops = 0.
  - Chime counter = 0.
- Run mode: cnt and sec_tick update on the same edge, 1 cycle after the prescaler reaches CLK_HZ-1.
- Load: cnt equals the sanitised ld_val on the first edge at which ld is sampled high.
- Increment: cnt updates on the 3rd rising edge after inc goes high (2 synchroniser stages plus the edge register).
  - Holding inc high gives exactly one increment.
- Chime: chime rises on the same edge that cnt becomes hh:00:00 via a run tick.
- rst asserted at any time, including mid-tick or mid-increment, clears all state immediately and without waiting for clk.

## Configuration
- TOD_CHIME_EN defined:
  - A down-counter is loaded with CHIME_SECS on each run-mode rollover to mm:ss = 00:00.
  - chime = 1 while the counter is nonzero; the counter decrements on each subsequent tick.
  - Net effect: chime is high for exactly CHIME_SECS ticks.
  - Entering set mode or any ld clears the counter and chime.
  - Reaching hh:00:00 by load or manual set never starts the chime.
- TOD_CHIME_EN undefined: no chime counter exists and chime is tied to 0.

## Test plan
- Reset:
  - Stimulus: CLK_HZ = 4; assert rst asynchronously mid-cycle.
  - Response: cnt = 000000, sec_tick = 0 and chime = 0 immediately; after release, first sec_tick on the 4th edge and cnt = 000001.
- Rollover:
  - Stimulus: ld_val = 24'h235958, then run.
  - Response: cnt = 235959 after 4 clocks, then 000000 after 8 clocks; sec_tick high for one cycle each time.
- Set minutes:
  - Stimulus: cnt = 125930, set_mode = 1, sel = 01, one inc pulse.
  - Response: cnt = 120030 on the 3rd edge after inc rises; hours unchanged; no sec_tick.
- Load sanitising:
  - Stimulus: ld_val = 24'h2A6F45.
  - Response: cnt = 000045 (hours and minutes invalid, so zeroed).
- Chime with TOD_CHIME_EN:
  - Stimulus: load 095958, run.
  - Response: chime rises with cnt = 100000 and falls with cnt = 100005 (5 ticks, 20 clocks).
  - Same stimulus without the macro: chime stays 0.
- Load and tick collide:
  - Stimulus: ld = 1 on the tick cycle with ld_val = 24'h010203.
  - Response: cnt = 010203, sec_tick = 0; the next tick yields 010204.

Source files
------------

// File: rtl/tod_counter.sv
// 24-hour BCD time-of-day counter with 1 Hz prescaler, load, manual set and seconds strobe.
// Optional top-of-hour chime is built when TOD_CHIME_EN is defined; otherwise chime is tied low.
module tod_counter #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int CHIME_SECS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_mode,
    input  logic [1:0]  sel,
    input  logic        inc,
    input  logic        ld,
    input  logic [23:0] ld_val,
    output logic [23:0] cnt,
    output logic        sec_tick,
    output logic        chime
);

    localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc;
    logic          inc_s1, inc_s2, inc_s3;
    logic          tick, inc_edge, tick_taken;
    logic [8:0]    s_inc, m_inc, h_inc;
    logic [23:0]   cnt_next;

    // BCD pair increment returning {wrapped, next}; top is the last legal value of the pair.
    function automatic logic [8:0] inc_pair(input logic [7:0] p, input logic [7:0] top);
        if (p == top) begin
            inc_pair = {1'b1, 8'h00};
        end else if (p[3:0] == 4'd9) begin
            inc_pair = {1'b0, p[7:4] + 4'd1, 4'd0};
        end else begin
            inc_pair = {1'b0, p[7:4], p[3:0] + 4'd1};
        end
    endfunction

    // Packed BCD compares numerically like decimal once the low digit is known to be <= 9.
    function automatic logic pair_ok(input logic [7:0] p, input logic [7:0] top);
        pair_ok = (p[3:0] <= 4'd9) && (p <= top);
    endfunction

    // Next-time selection: load beats a set-mode increment, which beats the run tick.
    always_comb begin
        tick       = ~set_mode & (presc == PMAX);
        inc_edge   = inc_s2 & ~inc_s3;
        s_inc      = inc_pair(cnt[7:0],   8'h59);
        m_inc      = inc_pair(cnt[15:8],  8'h59);
        h_inc      = inc_pair(cnt[23:16], 8'h23);
        cnt_next   = cnt;
        tick_taken = 1'b0;
        if (ld) begin
            cnt_next[23:16] = pair_ok(ld_val[23:16], 8'h23) ? ld_val[23:16] : 8'h00;
            cnt_next[15:8]  = pair_ok(ld_val[15:8],  8'h59) ? ld_val[15:8]  : 8'h00;
            cnt_next[7:0]   = pair_ok(ld_val[7:0],   8'h59) ? ld_val[7:0]   : 8'h00;
        end else if (set_mode) begin
            if (inc_edge) begin
                case (sel)
                    2'b00:   cnt_next[7:0]   = s_inc[7:0];
                    2'b01:   cnt_next[15:8]  = m_inc[7:0];
                    2'b10:   cnt_next[23:16] = h_inc[7:0];
                    default: cnt_next        = cnt;
                endcase
            end else begin
                cnt_next = cnt;
            end
        end else if (tick) begin
            tick_taken    = 1'b1;
            cnt_next[7:0] = s_inc[7:0];
            if (s_inc[8]) begin
                cnt_next[15:8] = m_inc[7:0];
                if (m_inc[8]) begin
                    cnt_next[23:16] = h_inc[7:0];
                end else begin
                    cnt_next[23:16] = cnt[23:16];
                end
            end else begin
                cnt_next[15:8] = cnt[15:8];
            end
        end else begin
            tick_taken = 1'b0;
        end
    end

    // Prescaler, increment synchroniser, time register and seconds strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            inc_s1   <= 1'b0;
            inc_s2   <= 1'b0;
            inc_s3   <= 1'b0;
            cnt      <= 24'h000000;
            sec_tick <= 1'b0;
        end else begin
            presc    <= (set_mode || tick) ? '0 : presc + PW'(1);
            inc_s1   <= inc;
            inc_s2   <= inc_s1;
            inc_s3   <= inc_s2;
            cnt      <= cnt_next;
            sec_tick <= tick_taken;
        end
    end

`ifdef TOD_CHIME_EN
    localparam logic [3:0] CHIME_LOAD = 4'(CHIME_SECS);

    logic [3:0] chime_cnt, chime_cnt_next;

    // Chime starts only when a run tick lands on mm:ss = 00:00; set mode or load cancels it.
    always_comb begin
        chime_cnt_next = chime_cnt;
        if (ld || set_mode) begin
            chime_cnt_next = 4'd0;
        end else if (tick_taken) begin
            if (cnt_next[15:0] == 16'h0000) begin
                chime_cnt_next = CHIME_LOAD;
            end else if (chime_cnt != 4'd0) begin
                chime_cnt_next = chime_cnt - 4'd1;
            end else begin
                chime_cnt_next = chime_cnt;
            end
        end else begin
            chime_cnt_next = chime_cnt;
        end
    end

    // Chime counter and its registered output level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chime_cnt <= 4'd0;
            chime     <= 1'b0;
        end else begin
            chime_cnt <= chime_cnt_next;
            chime     <= (chime_cnt_next != 4'd0);
        end
    end
`else
    assign chime = 1'b0;
`endif

endmodule
